// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//
// Command-driven AXI4-lite master. A single-beat read or write request on the
// cmd_* valid/ready port becomes one AXI4-lite transaction. The read data, the
// bus response and the transaction latency are returned on the rsp_* port.
// Only one transaction is outstanding at a time.
//
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write                 1 = write, 0 = read
//   cmd_addr/wdata/wstrb      target byte address, write data, byte strobes
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata                 read data (0 for writes)
//   rsp_resp                  captured BRESP or RRESP
//   rsp_lat                   cycles from command accept to B/R handshake,
//                             saturating at 2^LAT_WIDTH-1
//   m_axi_*                   AXI4-lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [LAT_WIDTH-1:0]  rsp_lat,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_BR   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   aw_done;
    logic                   w_done;
    logic [LAT_WIDTH-1:0]   lat_cnt;
    logic                   cmd_fire;
    logic                   wr_both;

    function automatic logic [LAT_WIDTH-1:0] lat_inc(input logic [LAT_WIDTH-1:0] v);
        if (v == {LAT_WIDTH{1'b1}})
            return v;
        else
            return v + LAT_WIDTH'(1);
    endfunction

    assign cmd_fire = (state == S_IDLE) && cmd_valid;

    // In WR a channel is complete if its flag is set or its ready is seen
    // now; valid is high exactly while the flag is clear, so ready alone
    // means the handshake is happening this cycle.
    assign wr_both = (aw_done || m_axi_awready) && (w_done || m_axi_wready);

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (cmd_valid)     state_nx = cmd_write ? S_WR : S_RA;
            S_WR:   if (wr_both)       state_nx = S_BR;
            S_BR:   if (m_axi_bvalid)  state_nx = S_RSP;
            S_RA:   if (m_axi_arready) state_nx = S_RD;
            S_RD:   if (m_axi_rvalid)  state_nx = S_RSP;
            S_RSP:  if (rsp_ready)     state_nx = S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded only from state and completion flags, so no AXI input
    // reaches an AXI output combinationally.
    always_comb begin
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_WR: begin
                m_axi_awvalid = ~aw_done;
                m_axi_wvalid  = ~w_done;
            end
            S_BR:   m_axi_bready  = 1'b1;
            S_RA:   m_axi_arvalid = 1'b1;
            S_RD:   m_axi_rready  = 1'b1;
            S_RSP:  rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    // Registered address/data, completion flags, latency and response capture
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi_awaddr <= '0;
            m_axi_araddr <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            lat_cnt      <= '0;
            rsp_rdata    <= '0;
            rsp_resp     <= '0;
            rsp_lat      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        m_axi_awaddr <= cmd_addr;
                        m_axi_araddr <= cmd_addr;
                        m_axi_wdata  <= cmd_wdata;
                        m_axi_wstrb  <= cmd_wstrb;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        lat_cnt      <= '0;
                    end
                end
                S_WR: begin
                    lat_cnt <= lat_inc(lat_cnt);
                    if (m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wready)  w_done  <= 1'b1;
                end
                S_BR: begin
                    lat_cnt <= lat_inc(lat_cnt);
                    if (m_axi_bvalid) begin
                        rsp_rdata <= '0;
                        rsp_resp  <= m_axi_bresp;
                        // The handshake cycle itself is part of the latency
                        rsp_lat   <= lat_inc(lat_cnt);
                    end
                end
                S_RA: begin
                    lat_cnt <= lat_inc(lat_cnt);
                end
                S_RD: begin
                    lat_cnt <= lat_inc(lat_cnt);
                    if (m_axi_rvalid) begin
                        rsp_rdata <= m_axi_rdata;
                        rsp_resp  <= m_axi_rresp;
                        rsp_lat   <= lat_inc(lat_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
module tb_axi_lite_master;

    localparam int AW = 32;
    localparam int LW = 4;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [LW-1:0] rsp_lat;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = '0;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [31:0]   m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;

    axi_lite_master #(.ADDR_WIDTH(AW), .LAT_WIDTH(LW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]   rdata;
        logic [1:0]    resp;
        logic [LW-1:0] lat;
        bit            chk_rdata;
        bit            chk_lat;
    } exp_t;
    exp_t sb[$];
    int n_sent = 0;
    int rsp_cnt = 0;
    logic [31:0] last_rdata = '0;

    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;

    // slave configuration: a channel's ready/valid rises in the Nth cycle
    int aw_delay = 1, w_delay = 1, b_delay = 1, ar_delay = 1, r_delay = 1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    bit          rforce = 1'b0;
    logic [31:0] rforce_val = '0;

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit txn_aw = 1'b0, txn_w = 1'b0;
    int bready_viol = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;

    // GCD wrapper model: 0x00 ctrl(bit0 start)/status({done,busy}), 0x04 A, 0x08 B, 0x0C result
    logic [31:0] g_a = '0, g_b = '0, g_res = '0;
    bit g_busy = 1'b0, g_done = 1'b0;
    int g_tmr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] addr);
        case (addr[7:0])
            8'h00:   return {30'd0, g_done, g_busy};
            8'h04:   return g_a;
            8'h08:   return g_b;
            8'h0C:   return g_res;
            default: return 32'd0;
        endcase
    endfunction

    task automatic slave_write(input logic [31:0] addr, input logic [31:0] d);
        case (addr[7:0])
            8'h00: if (d[0]) begin g_busy = 1'b1; g_done = 1'b0; g_tmr = 6; end
            8'h04: g_a = d;
            8'h08: g_b = d;
            default: ;
        endcase
    endtask

    // Slave BFM + monitor: drive slave signals on negedge, evaluate the
    // handshakes that the next posedge will complete at negedge+1.
    always @(negedge aclk) begin
        if (m_axi_awvalid) aw_cnt++; else aw_cnt = 0;
        m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
        if (m_axi_wvalid) w_cnt++; else w_cnt = 0;
        m_axi_wready = m_axi_wvalid && (w_cnt >= w_delay);
        if (m_axi_bready) b_cnt++; else b_cnt = 0;
        m_axi_bvalid = m_axi_bready && (b_cnt >= b_delay);
        m_axi_bresp  = m_axi_bvalid ? bresp_cfg : 2'b00;
        if (m_axi_arvalid) ar_cnt++; else ar_cnt = 0;
        m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
        if (m_axi_rready) r_cnt++; else r_cnt = 0;
        m_axi_rvalid = m_axi_rready && (r_cnt >= r_delay);
        m_axi_rdata  = m_axi_rvalid ? (rforce ? rforce_val : slave_read(s_araddr)) : 32'd0;
        m_axi_rresp  = m_axi_rvalid ? rresp_cfg : 2'b00;
        if (g_busy) begin
            if (g_tmr == 0) begin g_busy = 1'b0; g_done = 1'b1; g_res = gcd(g_a, g_b); end
            else g_tmr--;
        end
        #1;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_hs++; txn_aw = 1'b1; s_awaddr = m_axi_awaddr;
            check("awaddr", m_axi_awaddr, cur_addr);
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_hs++; txn_w = 1'b1; s_wdata = m_axi_wdata;
            check("wdata_wstrb", {m_axi_wstrb, m_axi_wdata}, {cur_wstrb, cur_wdata});
        end
        if (m_axi_bready && !(txn_aw && txn_w)) bready_viol++;
        if (m_axi_bready && m_axi_bvalid) begin
            b_hs++; slave_write(s_awaddr, s_wdata); txn_aw = 1'b0; txn_w = 1'b0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_hs++; s_araddr = m_axi_araddr;
            check("araddr", m_axi_araddr, cur_addr);
        end
        if (m_axi_rvalid && m_axi_rready) r_hs++;
        if (rsp_valid && rsp_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_resp", rsp_resp, e.resp);
                if (e.chk_rdata) check("rsp_rdata", rsp_rdata, e.rdata);
                if (e.chk_lat)   check("rsp_lat", rsp_lat, e.lat);
            end
            last_rdata = rsp_rdata;
            rsp_cnt++;
        end
    end

    task automatic drive_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws);
        int k;
        @(negedge aclk);
        cur_addr = addr; cur_wdata = wd; cur_wstrb = ws;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin @(negedge aclk); k++; end
        check("cmd_accept", cmd_ready, 1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] er, input logic [1:0] eresp,
                         input int elat, input bit crd, input bit clat);
        exp_t e;
        e.rdata = er; e.resp = eresp; e.lat = LW'(elat); e.chk_rdata = crd; e.chk_lat = clat;
        sb.push_back(e);
        n_sent++;
        drive_cmd(wr, addr, wd, ws);
    endtask

    task automatic wait_all();
        int k;
        k = 0;
        while (rsp_cnt < n_sent && k < 400) begin @(negedge aclk); k++; end
        @(negedge aclk);
        check("rsp_count", rsp_cnt, n_sent);
    endtask

    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] er, input logic [1:0] eresp,
                        input int elat, input bit crd, input bit clat);
        issue(wr, addr, wd, ws, er, eresp, elat, crd, clat);
        wait_all();
    endtask

    task automatic clr_counts();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; bready_viol = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] held;
        // ---- reset state ----
        repeat (2) @(negedge aclk);
        #2;
        check("rst_handshakes",
              {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready},
              7'b1000000);
        check("rst_data", {m_axi_awaddr, m_axi_wdata, m_axi_araddr}, 96'd0);
        check("rst_rsp", {rsp_rdata, rsp_resp, rsp_lat, m_axi_wstrb}, '0);
        @(negedge aclk);
        areset = 1'b0;

        // ---- GCD wrapper ----
        send(1, 32'h04, 32'd48, 4'hF, 32'd0, 2'b00, 2, 1, 1);
        send(1, 32'h08, 32'd18, 4'hF, 32'd0, 2'b00, 2, 1, 1);
        send(1, 32'h00, 32'd1,  4'hF, 32'd0, 2'b00, 2, 1, 1);
        for (int p = 0; p < 40; p++) begin
            send(0, 32'h00, 32'd0, 4'h0, 32'd0, 2'b00, 2, 0, 1);
            if (last_rdata[1]) break;
        end
        check("gcd_done_bit", last_rdata[1], 1);
        send(0, 32'h0C, 32'd0, 4'h0, 32'd6, 2'b00, 2, 1, 1);

        // ---- AW/W ordering ----
        clr_counts(); aw_delay = 3; w_delay = 1;
        send(1, 32'h100, 32'hA5A5_0001, 4'h3, 32'd0, 2'b00, 4, 1, 1);
        check("case_a_hs", {8'(aw_hs), 8'(w_hs), 8'(b_hs), 8'(bready_viol)}, {8'd1, 8'd1, 8'd1, 8'd0});
        clr_counts(); aw_delay = 1; w_delay = 1; bresp_cfg = 2'b11;
        send(1, 32'h104, 32'hA5A5_0002, 4'hC, 32'd0, 2'b11, 2, 1, 1);
        check("case_b_hs", {8'(aw_hs), 8'(w_hs), 8'(b_hs), 8'(bready_viol)}, {8'd1, 8'd1, 8'd1, 8'd0});
        clr_counts(); aw_delay = 1; w_delay = 5; bresp_cfg = 2'b01;
        send(1, 32'h108, 32'hA5A5_0003, 4'h1, 32'd0, 2'b01, 6, 1, 1);
        check("case_c_hs", {8'(aw_hs), 8'(w_hs), 8'(b_hs), 8'(bready_viol)}, {8'd1, 8'd1, 8'd1, 8'd0});
        w_delay = 1; bresp_cfg = 2'b00;

        // ---- delayed read with SLVERR ----
        r_delay = 10; rforce = 1'b1; rforce_val = 32'hDEAD_BEEF; rresp_cfg = 2'b10;
        send(0, 32'h200, 32'd0, 4'h0, 32'hDEAD_BEEF, 2'b10, 11, 1, 1);
        r_delay = 1; rresp_cfg = 2'b00; rforce_val = 32'h1234_5678;

        // ---- response backpressure ----
        @(negedge aclk);
        rsp_ready = 1'b0;
        issue(0, 32'h300, 32'd0, 4'h0, 32'h1234_5678, 2'b00, 2, 1, 1);
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge aclk); #2; k++; end
        check("bp_rsp_valid", rsp_valid, 1);
        held = rsp_rdata;
        clr_counts();
        @(negedge aclk);
        exp_bp_push: begin
            exp_t e;
            e.rdata = 32'd0; e.resp = 2'b00; e.lat = LW'(2); e.chk_rdata = 1; e.chk_lat = 1;
            sb.push_back(e);
            n_sent++;
        end
        cur_addr = 32'h304; cur_wdata = 32'h0BAD_F00D; cur_wstrb = 4'hF;
        cmd_write = 1'b1; cmd_addr = 32'h304; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge aclk); #2;
            check("bp_hold",
                  {rsp_valid, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready},
                  7'b1000000);
            check("bp_rdata", rsp_rdata, held);
        end
        @(negedge aclk);
        rsp_ready = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge aclk); k++; end
        check("bp_accept_after_release", {cmd_ready, 8'(aw_hs)}, {1'b1, 8'd0});
        @(negedge aclk);
        cmd_valid = 1'b0;
        wait_all();

        // ---- latency saturation ----
        b_delay = 40;
        send(1, 32'h400, 32'h5555_AAAA, 4'hF, 32'd0, 2'b00, 15, 1, 1);
        b_delay = 1;

        // ---- reset while in RD ----
        r_delay = 1000;
        drive_cmd(0, 32'h40, 32'd0, 4'h0);
        k = 0;
        while (!m_axi_rready && k < 20) begin @(negedge aclk); k++; end
        check("rd_reached", m_axi_rready, 1);
        areset = 1'b1;
        #1;
        check("mid_rst_handshakes",
              {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready},
              7'b1000000);
        check("mid_rst_data", {m_axi_araddr, rsp_rdata, rsp_lat}, '0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        r_delay = 1;
        @(negedge aclk); #2;
        check("post_rst_idle", {cmd_ready, rsp_valid}, 2'b10);
        send(1, 32'h08, 32'd7, 4'hF, 32'd0, 2'b00, 2, 1, 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
